// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and the IF/ID register.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_stall_cycles counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr,
    output logic        halted,
    output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redir_act;
    logic        advance;
    logic        halt_hit;
    logic        load;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign halted    = (state_q == HALT);

    always_comb begin
        state_d   = state_q;
        redir_act = 1'b0;
        advance   = 1'b0;
        halt_hit  = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (redirect_valid) begin
                    redir_act = 1'b1;
                end else begin
                    advance  = !stall && (!if_valid || id_ready);
                    halt_hit = HALT_ON_ZERO && advance && (imem_instr == 32'h0000_0000);
                    load     = advance && !halt_hit;
                    if (halt_hit)
                        state_d = HALT;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    redir_act = 1'b1;
                    state_d   = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Redirect flushes IF/ID and wins over both stall and advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= {RESET_PC[31:2], 2'b00};
            if_valid     <= 1'b0;
            if_pc        <= '0;
            if_pc_plus4  <= '0;
            if_instr     <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redir_act && (redirect_pc[1:0] != 2'b00);
            if (redir_act) begin
                pc       <= {redirect_pc[31:2], 2'b00};
                if_valid <= 1'b0;
            end else if (load) begin
                pc          <= pc_plus4;
                if_valid    <= 1'b1;
                if_pc       <= pc;
                if_pc_plus4 <= pc_plus4;
                if_instr    <= imem_instr;
            end else if (if_valid && id_ready) begin
                if_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (load)
                perf_fetched <= perf_fetched + 32'd1;
            if ((state_q == RUN) && !advance && !redir_act)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
// Honours FETCH_PERF_CNT_EN when the design is built with the counters.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic        halted;
    logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall_cycles;
`endif

    logic [31:0] mem [64];
    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[7:2]];

    fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .HALT_ON_ZERO(1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_ready      (id_ready),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_pc_plus4   (if_pc_plus4),
        .if_instr      (if_instr),
        .halted        (halted),
        .misalign_err  (misalign_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched     (perf_fetched),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        restart();
        rst = 1'b1;
        #2;
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
        total++; if (if_pc !== 32'h0 || if_pc_plus4 !== 32'h0 || if_instr !== 32'h0) begin
            bad++; $display("FAIL reset_ifid: got %h %h %h want zeros", if_pc, if_pc_plus4, if_instr); end
        total++; if (halted !== 1'b0 || misalign_err !== 1'b0) begin
            bad++; $display("FAIL reset_flags: got halted=%b mis=%b want 0 0", halted, misalign_err); end
        rst = 1'b0;
    endtask

    task automatic test_straight_line();
        restart();
        tick();
        total++; if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL idle_cycle: got valid=%b addr=%h want 0 00000000", if_valid, imem_addr); end
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            total++; if (if_valid !== 1'b1 || if_pc !== 32'(i * 4) || if_instr !== mem[i] || if_pc_plus4 !== 32'(i * 4 + 4)) begin
                bad++; $display("FAIL straight_%0d: got v=%b pc=%h instr=%h p4=%h want 1 %h %h %h",
                                i, if_valid, if_pc, if_instr, if_pc_plus4, 32'(i * 4), mem[i], 32'(i * 4 + 4)); end
        end
        total++; if (imem_addr !== 32'hC) begin bad++; $display("FAIL straight_addr: got %h want 0000000c", imem_addr); end
    endtask

    task automatic test_backpressure();
        restart();
        tick();
        tick();
        tick();
        id_ready = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            total++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== mem[1] || imem_addr !== 32'h8) begin
                bad++; $display("FAIL bp_hold_%0d: got v=%b pc=%h instr=%h addr=%h want 1 00000004 %h 00000008",
                                i, if_valid, if_pc, if_instr, imem_addr, mem[1]); end
        end
        id_ready = 1'b1;
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== mem[2]) begin
            bad++; $display("FAIL bp_resume: got v=%b pc=%h instr=%h want 1 00000008 %h", if_valid, if_pc, if_instr, mem[2]); end
    endtask

    task automatic test_redirect_stall();
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] sc0;
        sc0 = perf_stall_cycles;
`endif
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_002A;
        tick();
        total++; if (imem_addr !== 32'h28 || if_valid !== 1'b0 || misalign_err !== 1'b1) begin
            bad++; $display("FAIL redir_stall: got addr=%h v=%b mis=%b want 00000028 0 1", imem_addr, if_valid, misalign_err); end
        redirect_valid = 1'b0;
        tick();
        total++; if (imem_addr !== 32'h28 || if_valid !== 1'b0 || misalign_err !== 1'b0) begin
            bad++; $display("FAIL redir_held: got addr=%h v=%b mis=%b want 00000028 0 0", imem_addr, if_valid, misalign_err); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (perf_stall_cycles !== sc0 + 32'd1) begin
            bad++; $display("FAIL perf_stall: got %0d want %0d", perf_stall_cycles, sc0 + 32'd1); end
`endif
        stall = 1'b0;
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h28 || if_instr !== mem[10]) begin
            bad++; $display("FAIL redir_resume: got v=%b pc=%h instr=%h want 1 00000028 %h", if_valid, if_pc, if_instr, mem[10]); end
    endtask

    task automatic test_halt();
        tick();
        total++; if (if_pc !== 32'h2C || halted !== 1'b0) begin
            bad++; $display("FAIL halt_pre: got pc=%h halted=%b want 0000002c 0", if_pc, halted); end
        tick();
        total++; if (halted !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'h30) begin
            bad++; $display("FAIL halt_enter: got h=%b v=%b addr=%h want 1 0 00000030", halted, if_valid, imem_addr); end
        tick();
        total++; if (halted !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'h30) begin
            bad++; $display("FAIL halt_stay: got h=%b v=%b addr=%h want 1 0 00000030", halted, if_valid, imem_addr); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        total++; if (halted !== 1'b0 || imem_addr !== 32'h0 || misalign_err !== 1'b0) begin
            bad++; $display("FAIL halt_exit: got h=%b addr=%h mis=%b want 0 00000000 0", halted, imem_addr, misalign_err); end
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0050_0093) begin
            bad++; $display("FAIL halt_restart: got v=%b pc=%h instr=%h want 1 00000000 00500093", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_async_reset();
        for (int unsigned i = 0; i < 5; i++) tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h14) begin
            bad++; $display("FAIL ar_pre: got v=%b pc=%h want 1 00000014", if_valid, if_pc); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (if_valid !== 1'b0 || imem_addr !== 32'h0 || halted !== 1'b0) begin
            bad++; $display("FAIL ar_immediate: got v=%b addr=%h h=%b want 0 00000000 0", if_valid, imem_addr, halted); end
        tick();
        rst = 1'b0;
        tick();
        total++; if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL ar_idle: got v=%b addr=%h want 0 00000000", if_valid, imem_addr); end
        tick();
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
            bad++; $display("FAIL ar_fetch: got v=%b pc=%h want 1 00000000", if_valid, if_pc); end
    endtask

    task automatic test_wrap();
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] pf0;
`endif
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFC || if_valid !== 1'b0) begin
            bad++; $display("FAIL wrap_redir: got addr=%h v=%b want fffffffc 0", imem_addr, if_valid); end
`ifdef FETCH_PERF_CNT_EN
        pf0 = perf_fetched;
`endif
        tick();
        total++; if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0 || if_instr !== mem[63] || imem_addr !== 32'h0) begin
            bad++; $display("FAIL wrap_load: got pc=%h p4=%h instr=%h addr=%h want fffffffc 00000000 %h 00000000",
                            if_pc, if_pc_plus4, if_instr, imem_addr, mem[63]); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (perf_fetched !== pf0 + 32'd1) begin
            bad++; $display("FAIL perf_fetch1: got %0d want %0d", perf_fetched, pf0 + 32'd1); end
`endif
        tick();
        total++; if (if_pc !== 32'h0 || if_instr !== 32'h0050_0093) begin
            bad++; $display("FAIL wrap_next: got pc=%h instr=%h want 00000000 00500093", if_pc, if_instr); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (perf_fetched !== pf0 + 32'd2) begin
            bad++; $display("FAIL perf_fetch2: got %0d want %0d", perf_fetched, pf0 + 32'd2); end
`endif
    endtask

    initial begin
        for (int unsigned i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0]  = 32'h0050_0093;
        mem[1]  = 32'h00A0_0113;
        mem[2]  = 32'h0020_81B3;
        mem[12] = 32'h0000_0000;
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b1;
        #3;
        test_reset();
        test_straight_line();
        test_backpressure();
        test_redirect_stall();
        test_halt();
        test_async_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
